// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
//   Bundles every non-clock signal between the decode side (IF/ID register,
//   register file, WB bypass, hazard/flush control) and the ID->EX pipeline
//   register.
//
// Handshake semantics (the one place they are written down):
//   id_valid  - the IF/ID register holds a real instruction this cycle.
//   id_stall  - combinational "not ready": while high, IF/ID and PC must hold
//               so the same instruction is presented again next cycle.
//               An instruction is consumed at a posedge where id_stall==0.
//   stall_in  - downstream EX/MEM is not ready; the ID->EX register holds.
//   flush     - kill whatever enters EX at this posedge; beats stall_in.
//
// Parameter: CTRL_W - width of the opaque EX/MEM/WB control bundle.
// Modports : master - decode side / testbench (drives id_*, data*, wb_*,
//                     stall_in, flush; observes id_stall and ex_*)
//            slave  - the id_ex_stage register itself
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int CTRL_W = 8
);
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_regWrite;
    logic              id_memRead;
    logic [31:0]       data1;
    logic [31:0]       data2;
    logic              wb_regWrite;
    logic [4:0]        wb_writeReg;
    logic [31:0]       wb_writeData;
    logic              stall_in;
    logic              flush;

    logic              id_stall;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_imm;
    logic [31:0]       ex_opA;
    logic [31:0]       ex_opB;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_regWrite;
    logic              ex_memRead;

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_rd, id_imm, id_ctrl,
               id_regWrite, id_memRead, data1, data2,
               wb_regWrite, wb_writeReg, wb_writeData, stall_in, flush,
        input  id_stall, ex_valid, ex_pc, ex_imm, ex_opA, ex_opB,
               ex_rs, ex_rt, ex_rd, ex_ctrl, ex_regWrite, ex_memRead
    );

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_rd, id_imm, id_ctrl,
               id_regWrite, id_memRead, data1, data2,
               wb_regWrite, wb_writeReg, wb_writeData, stall_in, flush,
        output id_stall, ex_valid, ex_pc, ex_imm, ex_opA, ex_opB,
               ex_rs, ex_rt, ex_rd, ex_ctrl, ex_regWrite, ex_memRead
    );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID->EX pipeline register of a 5-stage MIPS pipeline. Latches the
//   register-file operands and decoded fields every clock, detects load-use
//   hazards (inserting exactly one bubble and holding IF/ID via id_stall),
//   and honours downstream stall_in and flush.
//
// Ports:
//   clk  - single clock, all state changes on posedge
//   rst  - synchronous, active-low reset
//   bus  - id_ex_stage_if.slave: id_* / data1 / data2 / wb_* / stall_in /
//          flush in; id_stall (combinational) and registered ex_* out
//
// Build option: define WB_BYPASS_EN to forward the WB write data into the
//   captured operands (for a regfile that writes on posedge). Without it the
//   wb_* inputs are ignored and operands come from data1/data2 only.
//
// Priority at posedge: reset > flush > stall_in > hazard > capture.
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CTRL_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    logic              valid_q;
    logic [31:0]       pc_q;
    logic [31:0]       imm_q;
    logic [31:0]       opa_q;
    logic [31:0]       opb_q;
    logic [4:0]        rs_q;
    logic [4:0]        rt_q;
    logic [4:0]        rd_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              reg_write_q;
    logic              mem_read_q;

    logic              hazard;
    logic [31:0]       opa_next;
    logic [31:0]       opb_next;

    // A load sitting in EX whose destination is read by the instruction in
    // ID cannot be forwarded in time; $0 never creates a dependency.
    assign hazard = valid_q & mem_read_q & (rt_q != 5'd0) & bus.id_valid &
                    ((rt_q == bus.id_rs) | (rt_q == bus.id_rt));

    assign bus.id_stall = bus.stall_in | hazard;

    // Operand selection. $0 is forced to zero last so it overrides both the
    // regfile data and any (illegal) bypass of register 0.
    always_comb begin
        opa_next = bus.data1;
        opb_next = bus.data2;
`ifdef WB_BYPASS_EN
        if (bus.wb_regWrite && (bus.wb_writeReg != 5'd0) &&
            (bus.wb_writeReg == bus.id_rs)) begin
            opa_next = bus.wb_writeData;
        end
        if (bus.wb_regWrite && (bus.wb_writeReg != 5'd0) &&
            (bus.wb_writeReg == bus.id_rt)) begin
            opb_next = bus.wb_writeData;
        end
`endif
        if (bus.id_rs == 5'd0) begin
            opa_next = '0;
        end
        if (bus.id_rt == 5'd0) begin
            opb_next = '0;
        end
    end

`ifndef WB_BYPASS_EN
    // The regfile writes on negedge, so WB data is already on data1/data2.
    logic unused_wb;
    assign unused_wb = ^{bus.wb_regWrite, bus.wb_writeReg, bus.wb_writeData};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else if (bus.flush || (!bus.stall_in && hazard)) begin
            // Flush and load-use bubble both kill the EX slot; the data
            // fields are meaningless once valid is low, so they simply hold.
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else if (!bus.stall_in) begin
            valid_q     <= bus.id_valid;
            pc_q        <= bus.id_pc;
            imm_q       <= bus.id_imm;
            opa_q       <= opa_next;
            opb_q       <= opb_next;
            rs_q        <= bus.id_rs;
            rt_q        <= bus.id_rt;
            rd_q        <= bus.id_rd;
            ctrl_q      <= bus.id_valid ? bus.id_ctrl : '0;
            reg_write_q <= bus.id_valid & bus.id_regWrite;
            mem_read_q  <= bus.id_valid & bus.id_memRead;
        end
    end

    assign bus.ex_valid    = valid_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_opA      = opa_q;
    assign bus.ex_opB      = opb_q;
    assign bus.ex_rs       = rs_q;
    assign bus.ex_rt       = rt_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_ctrl     = ctrl_q;
    assign bus.ex_regWrite = reg_write_q;
    assign bus.ex_memRead  = mem_read_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed vectors for id_ex_stage. The driver applies one vector per cycle
//   (at negedge+1) and pushes two expectations: id_stall for this cycle's
//   inputs, and the ex_* state after the following posedge. The monitor runs
//   at negedge+3 and pops whichever expectations are due in that cycle.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
    localparam int CTRL_W = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic        rw;
        logic        mr;
    } ex_t;

    localparam int EX_W  = $bits(ex_t);
    localparam int EXP_W = EX_W + 1;   // MSB: compare data fields too

`ifdef WB_BYPASS_EN
    localparam logic [31:0] EXP_B13 = 32'd9;
    localparam logic [31:0] EXP_A14 = 32'd9;
`else
    localparam logic [31:0] EXP_B13 = 32'd1;
    localparam logic [31:0] EXP_A14 = 32'h20;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    id_ex_stage_if #(.CTRL_W(CTRL_W)) bus ();

    id_ex_stage #(.CTRL_W(CTRL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int               exp_step_q[$];
    logic [0:0]       stall_q[$];
    int               stall_step_q[$];
    int               checks = 0;
    int               errors = 0;

    function automatic ex_t mk(input logic v, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [7:0] ctrl, input logic rw,
                               input logic mr);
        ex_t e;
        e.valid = v;  e.pc = pc;  e.imm = imm;  e.opa = a;  e.opb = b;
        e.rs = rs;    e.rt = rt;  e.rd = rd;    e.ctrl = ctrl;
        e.rw = rw;    e.mr = mr;
        return e;
    endfunction

    function automatic ex_t bubble();
        return mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] imm,
                          input logic [7:0] ctrl, input logic rw,
                          input logic mr, input logic [31:0] d1,
                          input logic [31:0] d2);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = rd;
        bus.id_imm      = imm;
        bus.id_ctrl     = ctrl;
        bus.id_regWrite = rw;
        bus.id_memRead  = mr;
        bus.data1       = d1;
        bus.data2       = d2;
    endtask

    task automatic step(input ex_t exp, input logic chk_data,
                        input logic exp_stall);
        stall_q.push_back(exp_stall);
        stall_step_q.push_back(cyc);
        exp_q.push_back({chk_data, exp});
        exp_step_q.push_back(cyc);
        @(negedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [EXP_W-1:0] ent;
        logic [0:0]       es;
        ex_t              exp_ex;
        ex_t              act;
        int               s;
        logic             bad;
        forever begin
            @(negedge clk);
            #3;
            while (stall_q.size() > 0 && stall_step_q[0] == cyc) begin
                es = stall_q.pop_front();
                s  = stall_step_q.pop_front();
                checks++;
                if (bus.id_stall !== es[0]) begin
                    errors++;
                    $display("FAIL id_stall step%0d: got %b expected %b",
                             s, bus.id_stall, es[0]);
                end
            end
            while (exp_q.size() > 0 && exp_step_q[0] + 1 == cyc) begin
                ent    = exp_q.pop_front();
                s      = exp_step_q.pop_front();
                exp_ex = ex_t'(ent[EX_W-1:0]);
                act    = mk(bus.ex_valid, bus.ex_pc, bus.ex_imm, bus.ex_opA,
                            bus.ex_opB, bus.ex_rs, bus.ex_rt, bus.ex_rd,
                            bus.ex_ctrl, bus.ex_regWrite, bus.ex_memRead);
                if (ent[EXP_W-1])
                    bad = (act !== exp_ex);
                else
                    bad = (act.valid !== exp_ex.valid) ||
                          (act.ctrl !== exp_ex.ctrl) ||
                          (act.rw !== exp_ex.rw) || (act.mr !== exp_ex.mr);
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL ex_regs step%0d: got %h expected %h (data checked=%b)",
                             s, act, exp_ex, ent[EXP_W-1]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        rst              = 1'b0;
        bus.stall_in     = 1'b0;
        bus.flush        = 1'b0;
        bus.wb_regWrite  = 1'b0;
        bus.wb_writeReg  = 5'd0;
        bus.wb_writeData = 32'd0;
        set_id(1, 32'h100, 1, 2, 3, 32'h10, 8'hAA, 1, 0, 32'd4, 32'd7);
        @(negedge clk);
        #1;

        // Reset held two cycles with a valid instruction present.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0), 1'b1, 1'b0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0), 1'b1, 1'b0);
        rst = 1'b1;
        step(mk(1, 32'h100, 32'h10, 32'd4, 32'd7, 1, 2, 3, 8'hAA, 1, 0), 1'b1, 1'b0);

        // lw $5, then add reading $5 through rs: one bubble, then capture.
        set_id(1, 32'h104, 1, 5, 0, 32'h8, 8'h11, 1, 1, 32'h40, 32'h55);
        step(mk(1, 32'h104, 32'h8, 32'h40, 32'h55, 1, 5, 0, 8'h11, 1, 1), 1'b1, 1'b0);
        set_id(1, 32'h108, 5, 6, 7, 32'h0, 8'h22, 1, 0, 32'h99, 32'h66);
        step(bubble(), 1'b0, 1'b1);
        step(mk(1, 32'h108, 32'h0, 32'h99, 32'h66, 5, 6, 7, 8'h22, 1, 0), 1'b1, 1'b0);

        // Downstream stall for three cycles while ID changes underneath.
        bus.stall_in = 1'b1;
        set_id(1, 32'h10C, 2, 3, 4, 32'h1, 8'h33, 0, 0, 32'h1, 32'h2);
        step(mk(1, 32'h108, 32'h0, 32'h99, 32'h66, 5, 6, 7, 8'h22, 1, 0), 1'b1, 1'b1);
        set_id(1, 32'h110, 8, 9, 10, 32'h2, 8'h44, 1, 0, 32'h81, 32'h92);
        step(mk(1, 32'h108, 32'h0, 32'h99, 32'h66, 5, 6, 7, 8'h22, 1, 0), 1'b1, 1'b1);
        set_id(1, 32'h114, 11, 12, 13, 32'h3, 8'h55, 1, 1, 32'hB1, 32'hC2);
        step(mk(1, 32'h108, 32'h0, 32'h99, 32'h66, 5, 6, 7, 8'h22, 1, 0), 1'b1, 1'b1);
        bus.stall_in = 1'b0;
        step(mk(1, 32'h114, 32'h3, 32'hB1, 32'hC2, 11, 12, 13, 8'h55, 1, 1), 1'b1, 1'b0);

        // Flush together with stall_in and a load-use hazard on $12.
        bus.stall_in = 1'b1;
        bus.flush    = 1'b1;
        set_id(1, 32'h118, 12, 1, 2, 32'h4, 8'h66, 1, 0, 32'h5, 32'h6);
        step(bubble(), 1'b0, 1'b1);
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        step(mk(1, 32'h118, 32'h4, 32'h5, 32'h6, 12, 1, 2, 8'h66, 1, 0), 1'b1, 1'b0);

        // $0 operand forced to zero; WB write of $3 in the same cycle.
        bus.wb_regWrite  = 1'b1;
        bus.wb_writeReg  = 5'd3;
        bus.wb_writeData = 32'd9;
        set_id(1, 32'h11C, 0, 3, 4, 32'h5, 8'h77, 1, 0, 32'hDEAD, 32'h1);
        step(mk(1, 32'h11C, 32'h5, 32'h0, EXP_B13, 0, 3, 4, 8'h77, 1, 0), 1'b1, 1'b0);
        set_id(1, 32'h120, 3, 0, 5, 32'h6, 8'h78, 0, 0, 32'h20, 32'hBEEF);
        step(mk(1, 32'h120, 32'h6, EXP_A14, 32'h0, 3, 0, 5, 8'h78, 0, 0), 1'b1, 1'b0);
        bus.wb_regWrite = 1'b0;

        // Load targeting $0 followed by a reader of $0: never a hazard.
        set_id(1, 32'h124, 1, 0, 0, 32'h7, 8'h13, 0, 1, 32'h30, 32'h31);
        step(mk(1, 32'h124, 32'h7, 32'h30, 32'h0, 1, 0, 0, 8'h13, 0, 1), 1'b1, 1'b0);
        set_id(1, 32'h128, 0, 0, 9, 32'h8, 8'h14, 1, 0, 32'h40, 32'h41);
        step(mk(1, 32'h128, 32'h8, 32'h0, 32'h0, 0, 0, 9, 8'h14, 1, 0), 1'b1, 1'b0);

        // Non-valid ID: control gated off, data still captured.
        set_id(0, 32'h12C, 1, 2, 3, 32'h9, 8'hFF, 1, 1, 32'h1, 32'h2);
        step(mk(0, 32'h12C, 32'h9, 32'h1, 32'h2, 1, 2, 3, 8'h00, 0, 0), 1'b1, 1'b0);

        // Load into $6, then a reader of $6 through rt.
        set_id(1, 32'h130, 0, 6, 0, 32'hA, 8'h21, 1, 1, 32'h7, 32'h8);
        step(mk(1, 32'h130, 32'hA, 32'h0, 32'h8, 0, 6, 0, 8'h21, 1, 1), 1'b1, 1'b0);
        set_id(1, 32'h134, 1, 6, 2, 32'hB, 8'h31, 1, 0, 32'h3, 32'h4);
        step(bubble(), 1'b0, 1'b1);
        step(mk(1, 32'h134, 32'hB, 32'h3, 32'h4, 1, 6, 2, 8'h31, 1, 0), 1'b1, 1'b0);

        // Let the monitor drain, then confirm nothing was left unchecked.
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || stall_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0",
                     exp_q.size(), stall_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
